// File: rtl/serial_logic32.sv
// Bit-serial bitwise logic unit: evaluates AND/NAND/OR/NOR/XOR/NOT DIGIT bits per clock.
// Optional result-is-zero flag enabled by defining SERIAL_LOGIC_ZERO_FLAG_EN.
module serial_logic32 #(
    parameter int WIDTH = 32,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [2:0]       in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_err,
    output logic             out_zero
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t           state_reg;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] result_reg;
    logic [2:0]       op_reg;
    logic [CW-1:0]    cnt_reg;
    logic             err_reg;
    logic [DIGIT-1:0] digit_next;
    logic             accept;

    // Reserved opcodes fall through to 0 so the result word comes out cleared.
    function automatic logic logic_bit(input logic [2:0] op, input logic a, input logic b);
        logic r;
        case (op)
            3'b000:  r = a & b;
            3'b001:  r = ~(a & b);
            3'b010:  r = a | b;
            3'b011:  r = ~(a | b);
            3'b100:  r = a ^ b;
            3'b101:  r = ~a;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < DIGIT; gi++) begin : g_digit
            assign digit_next[gi] = logic_bit(op_reg, a_reg[gi], b_reg[gi]);
        end
    endgenerate

    assign in_ready   = (state_reg == IDLE);
    assign out_valid  = (state_reg == DONE);
    assign accept     = in_valid && in_ready;
    // Result register is only exposed once complete, so no partial word leaks out.
    assign out_result = out_valid ? result_reg : '0;
    assign out_err    = err_reg;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg  <= IDLE;
            a_reg      <= '0;
            b_reg      <= '0;
            result_reg <= '0;
            op_reg     <= 3'b000;
            cnt_reg    <= '0;
            err_reg    <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        a_reg      <= in_a;
                        b_reg      <= in_b;
                        op_reg     <= in_op;
                        cnt_reg    <= '0;
                        result_reg <= '0;
                        err_reg    <= (in_op[2] && in_op[1]);
                        state_reg  <= BUSY;
                    end
                end
                BUSY: begin
                    result_reg <= {digit_next, result_reg[WIDTH-1:DIGIT]};
                    a_reg      <= a_reg >> DIGIT;
                    b_reg      <= b_reg >> DIGIT;
                    cnt_reg    <= cnt_reg + CW'(1);
                    if (cnt_reg == CW'(N - 1)) begin
                        state_reg <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

`ifdef SERIAL_LOGIC_ZERO_FLAG_EN
    logic zero_reg;

    // Starts optimistic on accept and drops on the first nonzero digit.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            zero_reg <= 1'b0;
        end else if (accept) begin
            zero_reg <= 1'b1;
        end else if (state_reg == BUSY && digit_next != '0) begin
            zero_reg <= 1'b0;
        end
    end

    assign out_zero = out_valid && zero_reg;
`else
    assign out_zero = 1'b0;
`endif

endmodule

// File: tb/tb_serial_logic32.sv
// Self-checking bench for serial_logic32: directed cases plus randomized ops
// compared against a word-level reference model.
module tb_serial_logic32;

    localparam int WIDTH = 32;
    localparam int DIGIT = 4;
    localparam int N     = WIDTH / DIGIT;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [2:0]       in_op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    logic             out_err;
    logic             out_zero;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;

    serial_logic32 #(.WIDTH(WIDTH), .DIGIT(DIGIT)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_op     (in_op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_result(out_result),
        .out_err   (out_err),
        .out_zero  (out_zero)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [WIDTH-1:0] ref_result(input logic [WIDTH-1:0] a,
                                                    input logic [WIDTH-1:0] b,
                                                    input logic [2:0] op);
        case (op)
            3'd0:    return a & b;
            3'd1:    return ~(a & b);
            3'd2:    return a | b;
            3'd3:    return ~(a | b);
            3'd4:    return a ^ b;
            3'd5:    return ~a;
            default: return '0;
        endcase
    endfunction

    function automatic logic ref_zero(input logic [WIDTH-1:0] r);
`ifdef SERIAL_LOGIC_ZERO_FLAG_EN
        return (r == '0);
`else
        return 1'b0;
`endif
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Issue one op, check the result and its flags, optionally stall the consumer.
    task automatic do_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic [2:0] op, input int stall, output int acc_cyc);
        logic [WIDTH-1:0] exp_r;
        int               lat;
        int               w;
        exp_r = ref_result(a, b, op);
        out_ready = (stall == 0);
        w = 0;
        while (!in_ready && w < 50) begin
            tick();
            w++;
        end
        check("issue_ready", {63'd0, in_ready}, 64'd1);
        in_a = a;
        in_b = b;
        in_op = op;
        in_valid = 1'b1;
        tick();
        acc_cyc = cyc;
        in_valid = 1'b0;
        check("busy_in_ready", {63'd0, in_ready}, 64'd0);
        lat = 0;
        while (!out_valid && lat < 50) begin
            in_a = $urandom;
            in_b = $urandom;
            in_op = 3'($urandom_range(0, 7));
            tick();
            lat++;
        end
        check("latency", 64'(lat), 64'(N));
        check("result", 64'(out_result), 64'(exp_r));
        check("err", {63'd0, out_err}, {63'd0, (op == 3'd6 || op == 3'd7)});
        check("zero", {63'd0, out_zero}, {63'd0, ref_zero(exp_r)});
        check("done_in_ready", {63'd0, in_ready}, 64'd0);
        for (int s = 0; s < stall; s++) begin
            in_valid = 1'($urandom_range(0, 1));
            in_a = $urandom;
            tick();
            check("stall_valid", {63'd0, out_valid}, 64'd1);
            check("stall_in_ready", {63'd0, in_ready}, 64'd0);
            check("stall_result", 64'(out_result), 64'(exp_r));
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        check("post_hs_valid", {63'd0, out_valid}, 64'd0);
        check("post_hs_ready", {63'd0, in_ready}, 64'd1);
        $display("op=%0d a=%08h b=%08h result=%08h exp=%08h err=%0b zero=%0b lat=%0d stall=%0d",
                 op, a, b, exp_r, exp_r, (op == 3'd6 || op == 3'd7), ref_zero(exp_r), lat, stall);
    endtask

    initial begin
        int acc1;
        int acc2;
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_op     = 3'd0;
        out_ready = 1'b1;
        repeat (3) tick();
        check("rst_in_ready", {63'd0, in_ready}, 64'd1);
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_result", 64'(out_result), 64'd0);
        check("rst_err", {63'd0, out_err}, 64'd0);
        check("rst_zero", {63'd0, out_zero}, 64'd0);
        reset_n = 1'b1;
        tick();

        do_op(32'hF0F0_1234, 32'hFF00_FF0F, 3'd0, 0, acc1);
        check("and_const", 64'(ref_result(32'hF0F0_1234, 32'hFF00_FF0F, 3'd0)), 64'hF000_1204);

        do_op(32'hAAAA_AAAA, 32'h5555_5555, 3'd4, 0, acc1);
        do_op(32'hAAAA_AAAA, 32'h5555_5555, 3'd3, 0, acc2);
        check("issue_interval", 64'(acc2 - acc1), 64'(N + 2));

        do_op(32'h0000_FFFF, 32'h1234_5678, 3'd5, 0, acc1);
        do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'd7, 0, acc1);
        do_op(32'hDEAD_BEEF, 32'h0F0F_F0F0, 3'd2, 20, acc1);

        // Reset asserted on the 4th BUSY edge.
        in_a = 32'h1234_5678;
        in_b = 32'h8765_4321;
        in_op = 3'd4;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (3) tick();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        check("midrst_valid", {63'd0, out_valid}, 64'd0);
        check("midrst_result", 64'(out_result), 64'd0);
        check("midrst_ready", {63'd0, in_ready}, 64'd1);
        $display("mid-op reset applied, in_ready=%0b out_valid=%0b", in_ready, out_valid);
        do_op(32'h1, 32'h2, 3'd2, 0, acc1);

        for (int i = 0; i < 30; i++) begin
            do_op($urandom, $urandom, 3'($urandom_range(0, 7)), $urandom_range(0, 3), acc1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
